wb_write_buffer: RTL and testbench

- In-order writeback buffer between the pipeline's writeback source and the register file's single write port.
- Accepts committed results (dest, value, write-enable) through a valid/ready handshake and queues them in a FIFO.
- Drains one entry per cycle onto the RF write-port signals dest_wb / result_wb / writeback_en.
- Exposes a pending-register mask and youngest-value forwarding so decode sees data not yet written to the RF.

---
 rtl/wb_write_buffer.sv | 166 ++++++++++++++++
 tb/tb_wb_write_buffer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_buffer.sv
// wb_write_buffer
//   In-order writeback buffer between the pipeline's writeback source and the
//   register file's single write port. Committed results are queued in a FIFO
//   and drained one per cycle onto registered RF write-port signals. A pending
//   register mask and (optionally) youngest-value forwarding let decode see
//   values that have not reached the RF yet.
//
//   Optional feature macro: WB_BYPASS_EN
//     defined   -> fwd1_*/fwd2_* search the FIFO and the output register
//     undefined -> fwd outputs are tied to 0 and no search logic is built
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   upstream handshake; a transfer happens on a posedge
//                       where both are high. in_ready = !full && !rst and never
//                       depends on drain_en or in_valid.
//   in_dest/in_result   destination index and value of the pushed result
//   in_wb_en            0 = result writes nothing; handshake completes, no entry
//   drain_en            RF write port free this cycle
//   src1/src2           decode read indices for forwarding
//   fwd1_*/fwd2_*       forwarding hit/value for src1/src2
//   pending_mask        bit i set while register i is queued or being written
//   count               number of valid FIFO entries
//   dest_wb/result_wb   registered RF write index/data
//   writeback_en        registered RF write strobe, one cycle per entry
module wb_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_dest,
    input  logic [31:0]      in_result,
    input  logic             in_wb_en,
    input  logic             drain_en,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    output logic             fwd1_hit,
    output logic [31:0]      fwd1_val,
    output logic             fwd2_hit,
    output logic [31:0]      fwd2_val,
    output logic [15:0]      pending_mask,
    output logic [PTR_W:0]   count,
    output logic [3:0]       dest_wb,
    output logic [31:0]      result_wb,
    output logic             writeback_en
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [3:0]       dest_q   [DEPTH];
    logic [31:0]      result_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             full;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] entry_valid;

    // Full/empty come from count, so wr_ptr == rd_ptr is never ambiguous.
    assign full     = (count_q == FULL_CNT);
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready && in_wb_en;
    // Uses the pre-edge count: an entry pushed into an empty FIFO waits one edge.
    assign pop      = drain_en && (count_q != '0);
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            writeback_en <= 1'b0;
            dest_wb      <= '0;
            result_wb    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                dest_wb   <= dest_q[rd_ptr];
                result_wb <= result_q[rd_ptr];
            end
            writeback_en <= pop;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: validity is tracked by rd_ptr/count only.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[wr_ptr]   <= in_dest;
            result_q[wr_ptr] <= in_result;
        end
    end

    // Slot i is valid when its distance from the head is below count.
    always_comb begin
        logic [PTR_W-1:0] offset;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PTR_W'(i) - rd_ptr;
            entry_valid[i] = ({1'b0, offset} < count_q);
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending_mask[dest_q[i]] = 1'b1;
            end
        end
        if (writeback_en) begin
            pending_mask[dest_wb] = 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    // Lowest priority first: the output register, then FIFO entries walked
    // oldest to youngest so a later (younger) match overrides an earlier one.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd1_hit = 1'b0;
        fwd1_val = '0;
        fwd2_hit = 1'b0;
        fwd2_val = '0;
        if (writeback_en && (dest_wb == src1)) begin
            fwd1_hit = 1'b1;
            fwd1_val = result_wb;
        end
        if (writeback_en && (dest_wb == src2)) begin
            fwd2_hit = 1'b1;
            fwd2_val = result_wb;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (((PTR_W+1)'(k) < count_q) && (dest_q[idx] == src1)) begin
                fwd1_hit = 1'b1;
                fwd1_val = result_q[idx];
            end
            if (((PTR_W+1)'(k) < count_q) && (dest_q[idx] == src2)) begin
                fwd2_hit = 1'b1;
                fwd2_val = result_q[idx];
            end
        end
    end
`else
    // Without bypass, decode stalls on pending_mask instead.
    logic unused_src;
    assign unused_src = ^{src1, src2};
    assign fwd1_hit   = 1'b0;
    assign fwd1_val   = '0;
    assign fwd2_hit   = 1'b0;
    assign fwd2_val   = '0;
`endif

endmodule

// File: tb/tb_wb_write_buffer.sv
// Testbench for wb_write_buffer: directed pushes, a writeback scoreboard with a
// negedge monitor, and directed checks of count/in_ready/pending_mask/forwarding.
module tb_wb_write_buffer;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_dest = '0;
    logic [31:0]      in_result = '0;
    logic             in_wb_en = 1'b0;
    logic             drain_en = 1'b0;
    logic [3:0]       src1 = '0;
    logic [3:0]       src2 = '0;
    logic             fwd1_hit;
    logic [31:0]      fwd1_val;
    logic             fwd2_hit;
    logic [31:0]      fwd2_val;
    logic [15:0]      pending_mask;
    logic [PTR_W:0]   count;
    logic [3:0]       dest_wb;
    logic [31:0]      result_wb;
    logic             writeback_en;

    logic [35:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    wb_write_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dest      (in_dest),
        .in_result    (in_result),
        .in_wb_en     (in_wb_en),
        .drain_en     (drain_en),
        .src1         (src1),
        .src2         (src2),
        .fwd1_hit     (fwd1_hit),
        .fwd1_val     (fwd1_val),
        .fwd2_hit     (fwd2_hit),
        .fwd2_val     (fwd2_val),
        .pending_mask (pending_mask),
        .count        (count),
        .dest_wb      (dest_wb),
        .result_wb    (result_wb),
        .writeback_en (writeback_en)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every RF write strobe must match the oldest expected entry.
    always @(negedge clk) begin
        logic [35:0] exp_w;
        if (writeback_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wb_unexpected: got dest %0d val 0x%0h, expected no write",
                         dest_wb, result_wb);
            end else begin
                exp_w = exp_q.pop_front();
                check("wb_data", {dest_wb, result_wb}, exp_w);
            end
        end
    end

    // ---------------- driver ----------------
    // Drives one push between negedge and posedge; returns just after the posedge.
    task automatic push(input logic [3:0] d, input logic [31:0] v, input logic we);
        logic acc;
        @(negedge clk);
        #1;
        in_valid  = 1'b1;
        in_dest   = d;
        in_result = v;
        in_wb_en  = we;
        #1;
        acc = in_ready;
        @(posedge clk);
        if (acc && we) exp_q.push_back({d, v});
        #1;
        in_valid = 1'b0;
        in_wb_en = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_wb_en", writeback_en, 0);
        check("rst_dest_wb", dest_wb, 0);
        check("rst_result_wb", result_wb, 0);
        check("rst_mask", pending_mask, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // 1: single push with drain enabled, minimum latency
        drain_en = 1'b1;
        push(4'd3, 32'h11, 1'b1);
        @(negedge clk);
        check("t1_count_1", count, 1);
        check("t1_mask_queued", pending_mask, 16'h0008);
        check("t1_wb_en_early", writeback_en, 0);
        @(negedge clk);
        check("t1_wb_en", writeback_en, 1);
        check("t1_dest_wb", dest_wb, 3);
        check("t1_mask_inflight", pending_mask, 16'h0008);
        check("t1_count_0", count, 0);
        @(negedge clk);
        check("t1_wb_en_drop", writeback_en, 0);
        check("t1_mask_clear", pending_mask, 0);

        // 2: fill to full, reject 5th push, drain in order (pointers wrap)
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) push(4'(i), 32'h20 + 32'(i), 1'b1);
        @(negedge clk);
        check("t2_count_full", count, 4);
        check("t2_in_ready_full", in_ready, 0);
        check("t2_mask", pending_mask, 16'h001E);
        push(4'd6, 32'h99, 1'b1);
        @(negedge clk);
        check("t2_count_after_reject", count, 4);
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_wb_pulse", writeback_en, 1);
        end
        @(negedge clk);
        check("t2_wb_end", writeback_en, 0);
        check("t2_count_empty", count, 0);
        drain_en = 1'b0;

        // 3: forwarding picks the youngest value, then the output register
        src1 = 4'd5;
        src2 = 4'd9;
        push(4'd5, 32'hA, 1'b1);
        push(4'd5, 32'hB, 1'b1);
        @(negedge clk);
        check("t3_count", count, 2);
        check("t3_fwd1_hit", fwd1_hit, BYP);
        check("t3_fwd1_val", fwd1_val, BYP ? 32'hB : 32'h0);
        check("t3_fwd2_hit", fwd2_hit, 0);
        check("t3_fwd2_val", fwd2_val, 0);
        check("t3_mask", pending_mask, 16'h0020);
        drain_en = 1'b1;
        @(negedge clk);
        check("t3_fifo_over_outreg_hit", fwd1_hit, BYP);
        check("t3_fifo_over_outreg_val", fwd1_val, BYP ? 32'hB : 32'h0);
        @(negedge clk);
        check("t3_outreg_hit", fwd1_hit, BYP);
        check("t3_outreg_val", fwd1_val, BYP ? 32'hB : 32'h0);
        check("t3_outreg_mask", pending_mask, 16'h0020);
        @(negedge clk);
        check("t3_nohit", fwd1_hit, 0);
        check("t3_nohit_val", fwd1_val, 0);
        check("t3_mask_clear", pending_mask, 0);

        // 4: in_wb_en=0 completes the handshake but stores nothing
        push(4'd7, 32'h77, 1'b0);
        @(negedge clk);
        check("t4_count", count, 0);
        check("t4_mask", pending_mask, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t4_no_wb", writeback_en, 0);
        end

        // 5: full FIFO with simultaneous push and drain -> push rejected
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) push(4'(8 + i), 32'h80 + 32'(i), 1'b1);
        @(negedge clk);
        check("t5_count_full", count, 4);
        #1;
        in_valid  = 1'b1;
        in_dest   = 4'd12;
        in_result = 32'hCC;
        in_wb_en  = 1'b1;
        drain_en  = 1'b1;
        #1;
        check("t5_in_ready_full_with_drain", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_wb_en = 1'b0;
        drain_en = 1'b0;
        @(negedge clk);
        check("t5_count_3", count, 3);
        check("t5_in_ready_1", in_ready, 1);
        check("t5_wb_en", writeback_en, 1);
        drain_en = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_count_drained", count, 0);
        drain_en = 1'b0;

        // 6: reset discards queued entries (index 15 included)
        for (int i = 13; i <= 15; i++) push(4'(i), 32'hD0 + 32'(i), 1'b1);
        @(negedge clk);
        check("t6_count", count, 3);
        check("t6_mask", pending_mask, 16'hE000);
        rst = 1'b1;
        #1;
        check("t6_in_ready_in_rst", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        drain_en = 1'b1;
        @(negedge clk);
        check("t6_count_rst", count, 0);
        check("t6_wb_en_rst", writeback_en, 0);
        check("t6_mask_rst", pending_mask, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_no_wb_after_rst", writeback_en, 0);
        end
        drain_en = 1'b0;

        // All expected writes must have been observed
        @(negedge clk);
        check("sb_drained", 36'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
